blank_wait_requester: RTL and testbench

//  Initiator side of the blank-count handshake used by the PAINT_ASM sequencer.
//  On a request from the paint FSM it pulses init to a blank counter and waits for that counter's CB (count-done) rising edge.
//  It then returns a one-cycle ack to the FSM. An optional watchdog re-arms the counter, or flags an error, if CB never arrives.

---
 rtl/blank_wait_requester_pkg.sv | 30 +++
 rtl/blank_wait_requester_watchdog.sv | 42 ++++
 rtl/blank_wait_requester.sv | 168 ++++++++++++++++
 tb/tb_blank_wait_requester.sv | 423 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/blank_wait_requester_pkg.sv
// Shared state encoding, defaults and output bundle for the blank-count wait initiator.
// The optional watchdog is selected by BLANK_WAIT_WATCHDOG_EN at the blank_wait_requester level.
package blank_wait_requester_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ARM  = 3'd1,
    ST_WAIT = 3'd2,
    ST_DONE = 3'd3,
    ST_ERR  = 3'd4
  } state_e;

  localparam int DEF_WD_CYCLES = 8_000_000;
  localparam int DEF_WD_W      = 23;
  localparam int INIT_W        = 4;
  localparam int RETRY_W       = 3;

  // Every FSM-visible output is registered from this bundle.
  typedef struct packed {
    logic busy;
    logic ack;
    logic err;
    logic init;
  } out_t;

  function automatic logic is_busy(input state_e s);
    return s != ST_IDLE;
  endfunction

endpackage

// File: rtl/blank_wait_requester_watchdog.sv
// bwr_watchdog: clear/enable cycle counter, tc pulses on the LIMIT-th consecutive enabled cycle.
// Compiled only with BLANK_WAIT_WATCHDOG_EN; no backpressure, tc is decoded from the held count.
`ifdef BLANK_WAIT_WATCHDOG_EN
module bwr_watchdog
  import blank_wait_requester_pkg::*;
#(
  parameter int LIMIT = DEF_WD_CYCLES,
  parameter int W     = DEF_WD_W
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = en & (cnt_q == LAST);

endmodule
`endif

// File: rtl/blank_wait_requester.sv
// Blank-count wait initiator: pulses init, waits for a CB rise, returns a one-cycle ack (req->init 1 cycle, cb rise->ack 2).
// req is only sampled in IDLE; BLANK_WAIT_WATCHDOG_EN adds the WAIT timeout, re-arm retries and sticky err.
module blank_wait_requester
  import blank_wait_requester_pkg::*;
#(
  parameter int INIT_LEN  = 1,
  parameter int WD_CYCLES = DEF_WD_CYCLES,
  parameter int WD_W      = DEF_WD_W,
  parameter int RETRIES   = 2,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  output logic             busy,
  output logic             ack,
  output logic             err,
  input  logic             clr_err,
  output logic             init,
  input  logic             cb,
  output logic [CNT_W-1:0] done_cnt
);

  localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_LEN - 1);

  state_e             state_q;
  state_e             state_d;
  logic               cb_q;
  logic               cb_rise;
  logic [INIT_W-1:0]  init_cnt_q;
  logic [INIT_W-1:0]  init_cnt_d;
  logic [CNT_W-1:0]   done_cnt_q;
  logic [CNT_W-1:0]   done_cnt_d;
  out_t               out_q;
  out_t               out_d;

  // A level already high when ARM starts has no edge, so it cannot complete the new wait.
  assign cb_rise = cb & ~cb_q;

`ifdef BLANK_WAIT_WATCHDOG_EN
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(RETRIES);

  logic               wd_tc;
  logic [RETRY_W-1:0] retry_q;
  logic [RETRY_W-1:0] retry_d;

  bwr_watchdog #(
    .LIMIT (WD_CYCLES),
    .W     (WD_W)
  ) u_watchdog (
    .clk (clk),
    .rst (rst),
    .clr (state_q != ST_WAIT),
    .en  (state_q == ST_WAIT),
    .tc  (wd_tc)
  );

  always_comb begin
    retry_d = retry_q;
    if (state_q == ST_IDLE) begin
      retry_d = '0;
    end else if ((state_q == ST_WAIT) && (state_d == ST_ARM)) begin
      retry_d = retry_q + RETRY_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      retry_q <= '0;
    end else begin
      retry_q <= retry_d;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = clr_err ^ (WD_CYCLES > 0) ^ (WD_W > 0) ^ (RETRIES > 0)
                    ^ (DEF_WD_W > 0) ^ (RETRY_W > 0);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          state_d = ST_ARM;
        end
      end
      ST_ARM: begin
        if (init_cnt_q == INIT_LAST) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // A rise on the final watchdog cycle still counts as success.
        if (cb_rise) begin
          state_d = ST_DONE;
        end
`ifdef BLANK_WAIT_WATCHDOG_EN
        else if (wd_tc) begin
          state_d = (retry_q < RETRY_MAX) ? ST_ARM : ST_ERR;
        end
`endif
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      ST_ERR: begin
`ifdef BLANK_WAIT_WATCHDOG_EN
        if (clr_err) begin
          state_d = ST_IDLE;
        end
`else
        state_d = ST_IDLE;
`endif
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    out_d      = '0;
    out_d.busy = is_busy(state_d);
    out_d.init = (state_d == ST_ARM);
    // ack trails DONE by one register so it lines up with the done_cnt update.
    out_d.ack  = (state_q == ST_DONE);
`ifdef BLANK_WAIT_WATCHDOG_EN
    out_d.err  = (state_d == ST_ERR);
`endif

    init_cnt_d = (state_q == ST_ARM) ? (init_cnt_q + INIT_W'(1)) : '0;

    done_cnt_d = done_cnt_q;
    if (state_q == ST_DONE) begin
      done_cnt_d = done_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cb_q       <= 1'b0;
      init_cnt_q <= '0;
      done_cnt_q <= '0;
      out_q      <= '0;
    end else begin
      cb_q       <= cb;
      init_cnt_q <= init_cnt_d;
      done_cnt_q <= done_cnt_d;
      out_q      <= out_d;
    end
  end

  assign busy     = out_q.busy;
  assign ack      = out_q.ack;
  assign err      = out_q.err;
  assign init     = out_q.init;
  assign done_cnt = done_cnt_q;

endmodule

// File: tb/tb_blank_wait_requester.sv
// Bench for blank_wait_requester: vector table, hand sequences for the corner cases, then random traffic vs a model.
// Timeout/retry expectations follow BLANK_WAIT_WATCHDOG_EN as seen by this compile.
module tb_blank_wait_requester;

  localparam int INIT_LEN  = 2;
  localparam int WD_CYCLES = 20;
  localparam int WD_W      = 8;
  localparam int RETRIES   = 1;
  localparam int CNT_W     = 8;

  logic             clk;
  logic             rst;
  logic             req;
  logic             cb;
  logic             clr_err;
  logic             busy;
  logic             ack;
  logic             err;
  logic             init;
  logic [CNT_W-1:0] done_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int ack_seen = 0;

  // Reference model: countdown of init cycles, WAIT age, attempt count, pending ack.
  int m_arm;
  bit m_wait;
  int m_wd;
  int m_tries;
  bit m_done;
  bit m_err;
  bit m_ack;
  int m_cnt;
  bit m_cbp;

  blank_wait_requester #(
    .INIT_LEN  (INIT_LEN),
    .WD_CYCLES (WD_CYCLES),
    .WD_W      (WD_W),
    .RETRIES   (RETRIES),
    .CNT_W     (CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .busy     (busy),
    .ack      (ack),
    .err      (err),
    .clr_err  (clr_err),
    .init     (init),
    .cb       (cb),
    .done_cnt (done_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500_000;
    $display("FAIL global_timeout: simulation exceeded its time budget");
    $fatal(1, "global timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 100)
        $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_arm = 0; m_wait = 0; m_wd = 0; m_tries = 0;
    m_done = 0; m_err = 0; m_ack = 0; m_cnt = 0; m_cbp = 0;
  endtask

  task automatic model_step();
    bit rise;
    if (!rst) begin
      model_reset();
      return;
    end
    rise  = cb && !m_cbp;
    m_ack = 0;
    if (m_done) begin
      m_done = 0;
      m_ack  = 1;
      m_cnt++;
    end else if (m_arm > 0) begin
      m_arm--;
      if (m_arm == 0) begin
        m_wait = 1;
        m_wd   = 0;
      end
    end else if (m_wait) begin
      if (rise) begin
        m_wait = 0;
        m_done = 1;
      end
`ifdef BLANK_WAIT_WATCHDOG_EN
      else if (m_wd == WD_CYCLES - 1) begin
        m_wait = 0;
        if (m_tries < RETRIES) begin
          m_tries++;
          m_arm = INIT_LEN;
        end else begin
          m_err = 1;
        end
      end
`endif
      else begin
        m_wd++;
      end
    end else if (m_err) begin
      if (clr_err) m_err = 0;
    end else if (req) begin
      m_tries = 0;
      m_arm   = INIT_LEN;
    end
    m_cbp = cb;
  endtask

  task automatic check_model();
    chk("model_busy", busy, ((m_arm > 0) || m_wait || m_done || m_err) ? 1 : 0);
    chk("model_init", init, (m_arm > 0) ? 1 : 0);
    chk("model_ack", ack, m_ack);
    chk("model_err", err, m_err);
    chk("model_done_cnt", done_cnt, m_cnt % (1 << CNT_W));
  endtask

  // One clock: model advances on the edge, DUT checked on the falling edge.
  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    cyc++;
    check_model();
    if (ack === 1'b1) ack_seen++;
  endtask

  task automatic reset_dut();
    req = 0; cb = 0; clr_err = 0; rst = 0;
    model_reset();
    repeat (2) cycle();
    rst = 1;
  endtask

  task automatic wait_init(input logic v, input int budget, output int n);
    n = 0;
    while (init !== v && n < budget) begin
      cycle();
      n++;
    end
    if (init !== v) begin
      n_checks++;
      n_fail++;
      $display("FAIL init_wait: init is %b, wanted %b within %0d cycles", init, v, budget);
    end
  endtask

  task automatic wait_ack(input int budget, output int n);
    n = 0;
    while (ack !== 1'b1 && n < budget) begin
      cycle();
      n++;
    end
    if (ack !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL ack_wait: no ack within %0d cycles", budget);
    end
  endtask

  // Blank counter: responds to an init pulse with a CB rise 'delay' cycles after init falls.
  task automatic blank_counter(input int delay, output int n_ack);
    int n;
    wait_init(1'b1, 10, n);
    wait_init(1'b0, 10, n);
    repeat (delay) cycle();
    cb = 1;
    wait_ack(10, n_ack);
    cb = 0;
  endtask

  typedef struct packed {
    logic       rst;
    logic       req;
    logic       cb;
    logic       clr;
    logic       busy;
    logic       ack;
    logic       init;
    logic       err;
    logic [7:0] cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic r, input logic q, input logic c, input logic cl,
                         input logic b, input logic a, input logic i, input logic e,
                         input logic [7:0] n);
    vec_t v;
    v.rst = r; v.req = q; v.cb = c; v.clr = cl;
    v.busy = b; v.ack = a; v.init = i; v.err = e; v.cnt = n;
    vecs.push_back(v);
  endtask

  initial begin
    int n;
    int k;
    int a0;
    int ack_cyc[3];

    rst = 0; req = 0; cb = 0; clr_err = 0;
    model_reset();

    //        rst req cb clr  busy ack init err cnt
    for (int i = 0; i < 5; i++)
      add_vec(0, 1, 0, 0,   0,   0,  0,   0,  0);
    add_vec(1, 1, 0, 0,     1,   0,  1,   0,  0);
    add_vec(1, 0, 0, 0,     1,   0,  1,   0,  0);
    add_vec(1, 0, 0, 0,     1,   0,  0,   0,  0);
    add_vec(1, 0, 1, 0,     1,   0,  0,   0,  0);
    add_vec(1, 0, 1, 0,     0,   1,  0,   0,  1);
    add_vec(1, 0, 1, 0,     0,   0,  0,   0,  1);
    add_vec(1, 1, 1, 0,     1,   0,  1,   0,  1);
    add_vec(1, 0, 1, 0,     1,   0,  1,   0,  1);
    add_vec(1, 0, 0, 0,     1,   0,  0,   0,  1);
    add_vec(1, 0, 0, 0,     1,   0,  0,   0,  1);
    add_vec(1, 0, 1, 0,     1,   0,  0,   0,  1);
    add_vec(1, 0, 0, 0,     0,   1,  0,   0,  2);
    add_vec(1, 0, 0, 0,     0,   0,  0,   0,  2);

    @(negedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst; req = vecs[i].req; cb = vecs[i].cb; clr_err = vecs[i].clr;
      if (!rst) model_reset();
      cycle();
      chk($sformatf("vec%0d_busy", i), busy, vecs[i].busy);
      chk($sformatf("vec%0d_ack", i), ack, vecs[i].ack);
      chk($sformatf("vec%0d_init", i), init, vecs[i].init);
      chk($sformatf("vec%0d_err", i), err, vecs[i].err);
      chk($sformatf("vec%0d_cnt", i), done_cnt, vecs[i].cnt);
    end

    // Normal wait: CB rises 10 cycles after init falls.
    reset_dut();
    req = 1;
    wait_init(1'b1, 10, n);
    chk("norm_req_to_init", n, 1);
    req = 0;
    wait_init(1'b0, 10, n);
    chk("norm_init_width", n, INIT_LEN);
    repeat (9) cycle();
    cb = 1;
    wait_ack(10, n);
    chk("norm_cb_to_ack", n, 2);
    chk("norm_busy_at_ack", busy, 0);
    chk("norm_cnt", done_cnt, 1);
    cb = 0;
    cycle();
    chk("norm_ack_width", ack, 0);

    // Stale CB held high before req.
    reset_dut();
    cb = 1;
    repeat (2) cycle();
    req = 1;
    cycle();
    req = 0;
    a0 = ack_seen;
    repeat (8) cycle();
    chk("stale_no_ack", ack_seen - a0, 0);
    chk("stale_busy", busy, 1);
    cb = 0;
    cycle();
    cb = 1;
    wait_ack(5, n);
    chk("stale_ack_lat", n, 2);
    cb = 0;

    // CB rising during ARM is ignored too.
    reset_dut();
    req = 1;
    cycle();
    req = 0;
    cb = 1;
    a0 = ack_seen;
    repeat (6) cycle();
    chk("arm_rise_no_ack", ack_seen - a0, 0);
    cb = 0;
    cycle();
    cb = 1;
    wait_ack(5, n);
    chk("arm_rise_ack_lat", n, 2);
    cb = 0;

    // Timeout, re-arm, then error.
    reset_dut();
    req = 1;
    cycle();
    req = 0;
    wait_init(1'b0, 10, n);
`ifdef BLANK_WAIT_WATCHDOG_EN
    wait_init(1'b1, 40, n);
    chk("to_retry_gap", n, WD_CYCLES);
    wait_init(1'b0, 10, n);
    k = 0;
    while (err !== 1'b1 && k < 40) begin
      cycle();
      k++;
    end
    chk("to_err_gap", k, WD_CYCLES);
    chk("to_err_busy", busy, 1);
    chk("to_err_init", init, 0);
    req = 1;
    repeat (5) cycle();
    chk("to_err_sticky", err, 1);
    chk("to_err_req_ignored", init, 0);
    req = 0;
    clr_err = 1;
    cycle();
    clr_err = 0;
    chk("to_clr_err", err, 0);
    chk("to_clr_busy", busy, 0);
`else
    repeat (40) cycle();
    chk("nowd_no_rearm", init, 0);
    chk("nowd_err", err, 0);
    chk("nowd_busy", busy, 1);
    cb = 1;
    wait_ack(5, n);
    chk("nowd_late_ack", n, 2);
    cb = 0;
`endif
    clr_err = 1;
    cycle();
    clr_err = 0;
    chk("clr_idle_err", err, 0);
    chk("clr_idle_busy", busy, 0);

    // CB rise on the last watchdog cycle wins over the timeout.
    reset_dut();
    req = 1;
    cycle();
    req = 0;
    wait_init(1'b0, 10, n);
    repeat (WD_CYCLES - 1) cycle();
    cb = 1;
    cycle();
    chk("race_no_rearm", init, 0);
    chk("race_busy", busy, 1);
    cycle();
    chk("race_ack", ack, 1);
    chk("race_err", err, 0);
    cb = 0;
    cycle();
    chk("race_idle", busy, 0);

    // Back-to-back waits with req held, then async reset mid-WAIT.
    reset_dut();
    req = 1;
    for (int i = 0; i < 3; i++) begin
      blank_counter(3, n);
      ack_cyc[i] = cyc;
    end
    chk("b2b_cnt", done_cnt, 3);
    chk("b2b_sep1", ack_cyc[1] - ack_cyc[0], 1 + INIT_LEN + 3 + 2);
    chk("b2b_sep2", ack_cyc[2] - ack_cyc[1], 1 + INIT_LEN + 3 + 2);
    wait_init(1'b1, 10, n);
    wait_init(1'b0, 10, n);
    repeat (3) cycle();
    #2;
    rst = 0;
    model_reset();
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_init", init, 0);
    chk("arst_ack", ack, 0);
    chk("arst_err", err, 0);
    chk("arst_cnt", done_cnt, 0);
    req = 0;
    cycle();
    rst = 1;

    // done_cnt wraps silently.
    reset_dut();
    req = 1;
    for (int i = 0; i < 256; i++) begin
      blank_counter(0, n);
      if (i == 254) chk("wrap_255", done_cnt, 255);
    end
    chk("wrap_0", done_cnt, 0);
    req = 0;
    repeat (2) cycle();

    // Random traffic against the model; CB activity alternates busy/quiet blocks.
    reset_dut();
    for (int i = 0; i < 3000; i++) begin
      int rate;
      rate = ((i / 500) % 2 == 0) ? 6 : 60;
      req = 1'($urandom_range(0, 1));
      clr_err = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, rate - 1) == 0) cb = ~cb;
      if (!rst) begin
        rst = 1;
      end else if ($urandom_range(0, 399) == 0) begin
        rst = 0;
        model_reset();
        #1;
        check_model();
      end
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
